hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Decides each cycle whether the instruction in D must stall. On a stall it drives the F/D-stage enables low and clears the D→E pipeline register, injecting a nop with E PC 0x00003000.
- Owns a small FSM and countdown that model the multi-cycle mult/div unit, so HI/LO users in D wait until the unit is idle.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, countdown width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- D_rs  input  5  rs field of the D instruction
- D_rt  input  5  rt field of the D instruction
- D_tuse_rs  input  2  cycles until D needs rs; 3 = not used
- D_tuse_rt  input  2  cycles until D needs rt; 3 = not used
- D_md_use  input  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_a3  input  5  destination register of the E instruction; 0 = none
- E_tnew  input  2  cycles until the E result is available
- M_a3  input  5  destination register of the M instruction
- M_tnew  input  2  cycles until the M result is available
- E_md_start  input  1  E instruction is mult/div this cycle
- E_md_div  input  1  with E_md_start: 1 = div/divu, 0 = mult/multu
- stall  output  1  combined stall request
- pc_en  output  1  PC write enable (= ~stall)
- d_en  output  1  F→D register enable (= ~stall)
- e_clr  output  1  clr of the D→E register (= stall)
- md_busy  output  1  mult/div unit busy

Behaviour:
- FSM states: IDLE and BUSY; countdown register cnt[CNT_W-1:0].
- Reset:
  - state=IDLE, cnt=0.
  - While reset is high, stall forced 0, so pc_en=1, d_en=1, e_clr=0, md_busy=0.
  - A mult/div in flight when reset asserts is discarded. There is no stall on the first cycle after reset.
- IDLE:
  - E_md_start=1 → at the clock edge load cnt = E_md_div ? DIV_CYCLES : MULT_CYCLES, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each edge:
  - If E_md_start=1, reload cnt from the new op and stay in BUSY (last start wins; should not occur because D stalls md instructions).
  - Else if cnt==1, cnt=0 and go to IDLE.
  - Else cnt=cnt-1.
- md_busy = E_md_start | (state==BUSY). Combinational, so the start cycle itself counts as busy.
- Register stall, combinational; r ∈ {rs, rt}:
  - stall_E_r = (D_r!=0) & (D_r==E_a3) & (D_tuse_r < E_tnew).
  - stall_M_r = (D_r!=0) & (D_r==M_a3) & (D_tuse_r < M_tnew).
  - Tuse=3 never stalls, since Tnew ≤ 2.
  - Register $0 never stalls.
- MD stall: stall_md = D_md_use & md_busy.
- stall = OR of all stall terms; pc_en, d_en and e_clr are pure functions of stall (zero latency).
- Stall sequencing:
  - The stalled D instruction is held.
  - E receives a bubble, which carries E_a3=0 and E_md_start=0 on the next cycle.
  - Stalls release automatically when Tnew drains or cnt reaches 0.
- Simultaneous register and MD stall: a single stall, with no priority issue.

Optional Feature:
- Macro HAZARD_STALL_STAT_EN.
- When defined:
  - Adds output stall_cycles [31:0], a saturating count of cycles with stall=1 since reset.
  - Adds output md_stall_cycles [31:0], counting cycles where stall_md=1.
  - Both reset to 0 and hold at 0xFFFFFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Tuse/Tnew encodings, including TUSE_NONE=2'd3.
  - Default values for MULT_CYCLES and DIV_CYCLES.
  - REG_ZERO=5'd0.
  - RESET_PC=32'h00003000.
- Sub-module md_busy_tracker contains the IDLE/BUSY FSM, cnt and md_busy.
- Register-hazard comparison and the stall OR stay in the top module.

Test Plan:
- Load-use: E_a3=8, E_tnew=2, D_rs=8, D_tuse_rs=1 → stall=1, pc_en=0, d_en=0, e_clr=1. Next cycle E_a3=0 and M_a3=8, M_tnew=1 → stall=0.
- $0 and unused sources: E_a3=0, D_rs=0, D_tuse_rs=0 → stall=0. E_a3=9, D_rt=9, D_tuse_rt=3 → stall=0.
- Mult then mflo:
  - E_md_start=1, E_md_div=0, D_md_use=1 → stall for 1+5=6 consecutive cycles.
  - md_busy falls after cnt reaches 0, and stall=0 on the 7th cycle.
- Div then non-md instruction: E_md_div=1 start, D_md_use=0 → stall=0 throughout; md_busy=1 for 11 cycles.
- Reset mid-divide: assert reset at cnt=4 → state IDLE, cnt=0, md_busy=0, stall=0 on the cycle after reset deasserts.
- With HAZARD_STALL_STAT_EN: the mult/mflo scenario → stall_cycles=6, md_stall_cycles=6. Force saturation preload → value holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and defaults for the MIPS pipeline core
package cpu_pkg;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] RESET_PC = 32'h00003000;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source stalls only when a producer ahead will not have its result
  // ready by the time the D instruction needs it; $0 is never a dependence.
  function automatic logic reg_hazard(input logic [4:0] d_r, input logic [1:0] tuse,
                                      input logic [4:0] a3, input logic [1:0] tnew);
    return (d_r != REG_ZERO) && (d_r == a3) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// rtl/md_busy_tracker.sv - models the multi-cycle mult/div unit occupancy
module md_busy_tracker
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // A new start always reloads, so the most recent op defines the busy window.
    if (md_start) begin
      cnt_d   = md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      state_d = MD_BUSY;
    end else if (state_q == MD_BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = MD_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle itself is busy so a following HI/LO user sees it at once.
  assign md_busy = ~reset & (md_start | (state_q == MD_BUSY));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - D-stage stall decision for the 5-stage MIPS core
// Optional stall statistics counters enabled by HAZARD_STALL_STAT_EN.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_a3,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_a3,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_clr,
`ifdef HAZARD_STALL_STAT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles,
`endif
  output logic        md_busy
);

  logic stall_e_rs, stall_e_rt, stall_m_rs, stall_m_rt;
  logic stall_reg, stall_md;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_tracker (
    .clk      (clk),
    .reset    (reset),
    .md_start (E_md_start),
    .md_div   (E_md_div),
    .md_busy  (md_busy)
  );

  assign stall_e_rs = reg_hazard(D_rs, D_tuse_rs, E_a3, E_tnew);
  assign stall_e_rt = reg_hazard(D_rt, D_tuse_rt, E_a3, E_tnew);
  assign stall_m_rs = reg_hazard(D_rs, D_tuse_rs, M_a3, M_tnew);
  assign stall_m_rt = reg_hazard(D_rt, D_tuse_rt, M_a3, M_tnew);

  assign stall_reg = stall_e_rs | stall_e_rt | stall_m_rs | stall_m_rt;
  assign stall_md  = D_md_use & md_busy;

  assign stall = ~reset & (stall_reg | stall_md);
  assign pc_en = ~stall;
  assign d_en  = ~stall;
  assign e_clr = stall;

`ifdef HAZARD_STALL_STAT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] md_stall_cycles_q, md_stall_cycles_d;

  always_comb begin
    stall_cycles_d    = stall_cycles_q;
    md_stall_cycles_d = md_stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFFFFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (stall_md && (md_stall_cycles_q != 32'hFFFFFFFF))
      md_stall_cycles_d = md_stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q    <= '0;
      md_stall_cycles_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      md_stall_cycles_q <= md_stall_cycles_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_a3, M_a3;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_md_use, E_md_start, E_md_div;
  logic       stall, pc_en, d_en, e_clr, md_busy;
`ifdef HAZARD_STALL_STAT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_md_use   (D_md_use),
    .E_a3       (E_a3),
    .E_tnew     (E_tnew),
    .M_a3       (M_a3),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stall      (stall),
    .pc_en      (pc_en),
    .d_en       (d_en),
    .e_clr      (e_clr),
`ifdef HAZARD_STALL_STAT_EN
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles),
`endif
    .md_busy    (md_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_md_use = 0;
    E_a3 = 0; E_tnew = 0; M_a3 = 0; M_tnew = 0; E_md_start = 0; E_md_div = 0;
  endtask

  task automatic test_reset();
    reset = 1; quiet();
    D_md_use = 1; E_md_start = 1; E_a3 = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = 0;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if ({pc_en, d_en, e_clr} !== 3'b110) begin fails++; $display("FAIL reset_enables got %b want 110", {pc_en, d_en, e_clr}); end
    checks++; if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
    step(); step();
    quiet(); reset = 0;
    #1;
    checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin fails++; $display("FAIL post_reset got stall=%b busy=%b want 0 0", stall, md_busy); end
  endtask

  task automatic test_load_use();
    quiet(); E_a3 = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = 1;
    #1;
    checks++; if ({stall, pc_en, d_en, e_clr} !== 4'b1001) begin fails++; $display("FAIL load_use got %b want 1001", {stall, pc_en, d_en, e_clr}); end
    step();
    E_a3 = 0; M_a3 = 8; M_tnew = 1;
    #1;
    checks++; if ({stall, pc_en, d_en, e_clr} !== 4'b0110) begin fails++; $display("FAIL load_use_release got %b want 0110", {stall, pc_en, d_en, e_clr}); end
    M_tnew = 2;
    #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL m_stage_rs got %b want 1", stall); end
    quiet(); E_a3 = 5; E_tnew = 1; D_rt = 5; D_tuse_rt = 0;
    #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL e_stage_rt got %b want 1", stall); end
    E_tnew = 0;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL e_stage_tnew0 got %b want 0", stall); end
    quiet(); M_a3 = 7; M_tnew = 2; D_rt = 7; D_tuse_rt = 1;
    #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL m_stage_rt got %b want 1", stall); end
    step();
  endtask

  task automatic test_zero_unused();
    quiet(); E_a3 = 0; E_tnew = 2; D_rs = 0; D_tuse_rs = 0;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reg_zero got %b want 0", stall); end
    quiet(); M_a3 = 0; M_tnew = 2; D_rt = 0; D_tuse_rt = 0;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reg_zero_m got %b want 0", stall); end
    quiet(); E_a3 = 9; E_tnew = 2; D_rt = 9; D_tuse_rt = 3;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL tuse_none got %b want 0", stall); end
    quiet(); E_a3 = 9; E_tnew = 2; D_rs = 10; D_tuse_rs = 0;
    #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reg_differ got %b want 0", stall); end
    quiet();
  endtask

  task automatic test_mult_mflo();
    quiet(); E_md_start = 1; E_md_div = 0; D_md_use = 1;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (stall !== (i < 6)) begin fails++; $display("FAIL mult_stall cyc%0d got %b want %b", i, stall, (i < 6)); end
      checks++; if (md_busy !== (i < 6)) begin fails++; $display("FAIL mult_busy cyc%0d got %b want %b", i, md_busy, (i < 6)); end
      step();
      E_md_start = 0;
    end
    quiet();
  endtask

  task automatic test_div_nonmd();
    quiet(); E_md_start = 1; E_md_div = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (md_busy !== (i < 11)) begin fails++; $display("FAIL div_busy cyc%0d got %b want %b", i, md_busy, (i < 11)); end
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL div_nonmd_stall cyc%0d got %b want 0", i, stall); end
      step();
      E_md_start = 0;
    end
    quiet();
  endtask

  task automatic test_back_to_back();
    quiet(); E_md_start = 1; E_md_div = 0; D_md_use = 1;
    E_a3 = 3; E_tnew = 2; D_rs = 3; D_tuse_rs = 0;
    #1;
    checks++; if ({stall, e_clr, pc_en} !== 3'b110) begin fails++; $display("FAIL combined_stall got %b want 110", {stall, e_clr, pc_en}); end
    step();
    E_md_start = 1; E_md_div = 0; E_a3 = 0; D_md_use = 0;
    step();
    E_md_start = 0;
    for (int i = 0; i < 4; i++) step();
    #1;
    checks++; if (md_busy !== 1'b1) begin fails++; $display("FAIL restart_busy got %b want 1", md_busy); end
    step();
    checks++; if (md_busy !== 1'b0) begin fails++; $display("FAIL restart_idle got %b want 0", md_busy); end
    quiet();
  endtask

  task automatic test_reset_mid_div();
    quiet(); E_md_start = 1; E_md_div = 1;
    step();
    E_md_start = 0;
    for (int i = 0; i < 6; i++) step();
    checks++; if (md_busy !== 1'b1) begin fails++; $display("FAIL mid_div_busy got %b want 1", md_busy); end
    reset = 1; D_md_use = 1;
    #1;
    checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin fails++; $display("FAIL in_reset got stall=%b busy=%b want 0 0", stall, md_busy); end
    step();
    reset = 0;
    #1;
    checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin fails++; $display("FAIL after_reset got stall=%b busy=%b want 0 0", stall, md_busy); end
    step();
    checks++; if (stall !== 1'b0 || md_busy !== 1'b0) begin fails++; $display("FAIL after_reset2 got stall=%b busy=%b want 0 0", stall, md_busy); end
    quiet();
  endtask

`ifdef HAZARD_STALL_STAT_EN
  task automatic test_stats();
    quiet(); reset = 1;
    step();
    reset = 0;
    #1;
    checks++; if (stall_cycles !== 32'd0 || md_stall_cycles !== 32'd0) begin fails++; $display("FAIL stat_reset got %0d %0d want 0 0", stall_cycles, md_stall_cycles); end
    test_mult_mflo();
    checks++; if (stall_cycles !== 32'd6) begin fails++; $display("FAIL stat_stall got %0d want 6", stall_cycles); end
    checks++; if (md_stall_cycles !== 32'd6) begin fails++; $display("FAIL stat_md_stall got %0d want 6", md_stall_cycles); end
    force dut.stall_cycles_q = 32'hFFFFFFFE;
    force dut.md_stall_cycles_q = 32'hFFFFFFFE;
    #1;
    release dut.stall_cycles_q;
    release dut.md_stall_cycles_q;
    E_md_start = 1; D_md_use = 1;
    step();
    step();
    step();
    checks++; if (stall_cycles !== 32'hFFFFFFFF) begin fails++; $display("FAIL stat_sat got %h want ffffffff", stall_cycles); end
    checks++; if (md_stall_cycles !== 32'hFFFFFFFF) begin fails++; $display("FAIL stat_md_sat got %h want ffffffff", md_stall_cycles); end
    quiet();
    for (int i = 0; i < 12; i++) step();
  endtask
`endif

  initial begin
    reset = 1; quiet();
    step();
    test_reset();
    test_load_use();
    test_zero_unused();
    test_mult_mflo();
    test_div_nonmd();
    test_back_to_back();
    test_reset_mid_div();
`ifdef HAZARD_STALL_STAT_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
